// File: rtl/conv_out_serializer_pkg.sv
// Shared types and default geometry for the column-convolution output path.
package conv_pkg;

   localparam int DATA_W    = 16;
   localparam int OUT_W     = 11;
   localparam int COLS      = 11;
   localparam int FRAME_LEN = COLS * OUT_W;

   typedef logic signed [DATA_W-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2
   } ser_state_t;

endpackage

// File: rtl/col_capture_bank.sv
// COLS x OUT_W sample bank with per-column write enables and one (col,row) read port.
// Define CONV_OUT_RELU_EN to clamp negative samples to zero as they are stored.
module col_capture_bank #(
   parameter int DATA_W = 16,
   parameter int OUT_W  = 11,
   parameter int COLS   = 11,
   parameter int CW     = 4,
   parameter int RW     = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [COLS-1:0]                 wr_en,
   input  logic [COLS*OUT_W*DATA_W-1:0]    wr_data,
   input  logic [CW-1:0]                   rd_col,
   input  logic [RW-1:0]                   rd_row,
   output logic signed [DATA_W-1:0]        rd_data
);

   logic signed [DATA_W-1:0] mem_r [COLS][OUT_W];

   function automatic logic signed [DATA_W-1:0] condition_sample(input logic signed [DATA_W-1:0] v);
`ifdef CONV_OUT_RELU_EN
      return v[DATA_W-1] ? {DATA_W{1'b0}} : v;
`else
      return v;
`endif
   endfunction

   // Store a whole column whenever its write enable is raised
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < OUT_W; r++) begin
               mem_r[c][r] <= {DATA_W{1'b0}};
            end
         end
      end else begin
         for (int c = 0; c < COLS; c++) begin
            if (wr_en[c]) begin
               for (int r = 0; r < OUT_W; r++) begin
                  mem_r[c][r] <= condition_sample(wr_data[(c*OUT_W + r)*DATA_W +: DATA_W]);
               end
            end
         end
      end
   end

   // Single asynchronous read port
   always_comb begin
      rd_data = mem_r[rd_col][rd_row];
   end

endmodule

// File: rtl/conv_out_serializer.sv
// Captures the per-column conv results and streams them out column-major over valid/ready.
// Optional ReLU at capture time is enabled by defining CONV_OUT_RELU_EN.
module conv_out_serializer #(
   parameter int DATA_W = 16,
   parameter int OUT_W  = 11,
   parameter int COLS   = 11
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [COLS-1:0]               done,
   input  logic [COLS*OUT_W*DATA_W-1:0]  in_values,
   output logic signed [DATA_W-1:0]      out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_last,
   output logic                          busy,
   output logic                          frame_done,
   output logic                          overrun
);
   import conv_pkg::*;

   localparam int CW = (COLS  > 1) ? $clog2(COLS)  : 1;
   localparam int RW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(OUT_W - 1);
   localparam logic [CW-1:0] COL_ONE = CW'(32'd1);
   localparam logic [RW-1:0] ROW_ONE = RW'(32'd1);

   ser_state_t                state_r;
   logic [COLS-1:0]           cap_r;
   logic [COLS-1:0]           done_q_r;
   logic [COLS-1:0]           rise_s;
   logic [COLS-1:0]           wr_en_s;
   logic [CW-1:0]             col_r;
   logic [RW-1:0]             row_r;
   logic [CW-1:0]             nxt_col_s;
   logic [RW-1:0]             nxt_row_s;
   logic [CW-1:0]             rd_col_s;
   logic [RW-1:0]             rd_row_s;
   logic                      fire_s;
   logic                      nxt_last_s;
   logic signed [DATA_W-1:0]  rd_data_s;

   col_capture_bank #(
      .DATA_W (DATA_W),
      .OUT_W  (OUT_W),
      .COLS   (COLS),
      .CW     (CW),
      .RW     (RW)
   ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en_s),
      .wr_data (in_values),
      .rd_col  (rd_col_s),
      .rd_row  (rd_row_s),
      .rd_data (rd_data_s)
   );

   // Rising-edge detect on done; a restart in the same cycle wins over capture
   always_comb begin
      rise_s = done & ~done_q_r;
      if ((state_r == CAPTURE) && !start) begin
         wr_en_s = rise_s;
      end else begin
         wr_en_s = {COLS{1'b0}};
      end
   end

   // Next beat address (row inner) and the bank read address for the output register
   always_comb begin
      fire_s = out_valid & out_ready;
      if (row_r == ROW_MAX) begin
         nxt_row_s = {RW{1'b0}};
         nxt_col_s = col_r + COL_ONE;
      end else begin
         nxt_row_s = row_r + ROW_ONE;
         nxt_col_s = col_r;
      end
      nxt_last_s = (nxt_col_s == COL_MAX) && (nxt_row_s == ROW_MAX);
      if ((state_r == DRAIN) && fire_s) begin
         rd_col_s = nxt_col_s;
         rd_row_s = nxt_row_s;
      end else begin
         rd_col_s = col_r;
         rd_row_s = row_r;
      end
   end

   // Frame FSM with registered stream outputs and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         cap_r      <= {COLS{1'b0}};
         done_q_r   <= {COLS{1'b0}};
         col_r      <= {CW{1'b0}};
         row_r      <= {RW{1'b0}};
         out_data   <= {DATA_W{1'b0}};
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         done_q_r   <= done;
         frame_done <= 1'b0;
         case (state_r)
            IDLE: begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               if (start) begin
                  cap_r   <= {COLS{1'b0}};
                  col_r   <= {CW{1'b0}};
                  row_r   <= {RW{1'b0}};
                  state_r <= CAPTURE;
                  busy    <= 1'b1;
               end else begin
                  busy    <= 1'b0;
               end
            end
            CAPTURE: begin
               busy <= 1'b1;
               if (start) begin
                  cap_r <= {COLS{1'b0}};
                  col_r <= {CW{1'b0}};
                  row_r <= {RW{1'b0}};
               end else if (&cap_r) begin
                  state_r   <= DRAIN;
                  out_valid <= 1'b1;
                  out_data  <= rd_data_s;
                  out_last  <= (rd_col_s == COL_MAX) && (rd_row_s == ROW_MAX);
               end else begin
                  cap_r <= cap_r | rise_s;
               end
            end
            DRAIN: begin
               if (start) begin
                  // Abort the stream: no out_last, no frame_done
                  overrun   <= 1'b1;
                  state_r   <= CAPTURE;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  cap_r     <= {COLS{1'b0}};
                  col_r     <= {CW{1'b0}};
                  row_r     <= {RW{1'b0}};
                  busy      <= 1'b1;
               end else if (fire_s) begin
                  if (out_last) begin
                     state_r    <= IDLE;
                     out_valid  <= 1'b0;
                     out_last   <= 1'b0;
                     frame_done <= 1'b1;
                     busy       <= 1'b0;
                  end else begin
                     col_r    <= nxt_col_s;
                     row_r    <= nxt_row_s;
                     out_data <= rd_data_s;
                     out_last <= nxt_last_s;
                  end
               end else begin
                  busy <= 1'b1;
               end
            end
            default: begin
               state_r   <= IDLE;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_out_serializer.sv
// Directed bench for conv_out_serializer: a queue-based frame model checked on every output cycle.
module tb_conv_out_serializer;

   localparam int DW = 16;
   localparam int OW = 11;
   localparam int NC = 11;
   localparam int NB = NC * OW;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   start;
   logic [NC-1:0]          done;
   logic [NC*OW*DW-1:0]    in_values;
   logic signed [DW-1:0]   out_data;
   logic                   out_valid;
   logic                   out_ready;
   logic                   out_last;
   logic                   busy;
   logic                   frame_done;
   logic                   overrun;

   conv_out_serializer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .done       (done),
      .in_values  (in_values),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // model state
   int                     mb [NC][OW];
   int                     exp_q [$];
   logic signed [DW-1:0]   beat_log [NB];
   int                     beat_cnt = 0;
   bit                     fd_pend = 0;
   bit                     fd_seen = 0;
   int                     fd_cyc = 0;
   int                     first_valid_cyc = 0;
   bit                     prev_valid = 0;
   bit                     hold_pend = 0;
   logic signed [DW-1:0]   hold_data;
   logic                   hold_last;
   bit                     rdy_mode = 0;
   logic [3:0]             pat = 4'b1001;

   task automatic chk(input string name, input longint got, input longint expv);
      nvec++;
      if (got !== expv) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
      end
   endtask

   // ready driver: constant high or the 1,0,0,1 pattern keyed on the cycle number
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rdy_mode ? pat[cyc % 4] : 1'b1;
      end
   end

   // compare process: every beat, every stall and every frame_done slot
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (hold_pend) begin
               chk("stall_valid", out_valid, 1);
               chk("stall_data", out_data, hold_data);
               chk("stall_last", out_last, hold_last);
            end
            hold_pend = 0;
            chk("frame_done", frame_done, fd_pend);
            if (fd_pend) begin
               chk("busy_at_frame_done", busy, 0);
               fd_cyc  = cyc;
               fd_seen = 1;
            end
            fd_pend = 0;
            if (out_valid && !prev_valid) first_valid_cyc = cyc;
            prev_valid = out_valid;
            if (out_valid && out_ready && !start) begin
               if (exp_q.size() == 0) begin
                  chk("extra_beat", 1, 0);
               end else begin
                  chk("beat_data", out_data, exp_q[0]);
                  chk("beat_last", out_last, (exp_q.size() == 1) ? 1 : 0);
                  if (beat_cnt < NB) beat_log[beat_cnt] = out_data;
                  beat_cnt++;
                  void'(exp_q.pop_front());
                  if (exp_q.size() == 0) fd_pend = 1;
               end
            end else if (out_valid && !out_ready && !start) begin
               hold_pend = 1;
               hold_data = out_data;
               hold_last = out_last;
            end
         end else begin
            prev_valid = 0;
            hold_pend  = 0;
            fd_pend    = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_val(input int c, input int r, input int v);
      logic signed [DW-1:0] s;
      s = DW'(v);
      in_values[(c*OW + r)*DW +: DW] = s;
      mb[c][r] = v;
   endtask

   task automatic fill_frame(input int base);
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < OW; r++)
            set_val(c, r, base + c*16 + r);
   endtask

   // expected stream: column-major, row inner, with ReLU when the feature is built in
   task automatic build_exp();
      int v;
      exp_q.delete();
      beat_cnt = 0;
      fd_seen  = 0;
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < OW; r++) begin
            v = mb[c][r];
`ifdef CONV_OUT_RELU_EN
            if (v < 0) v = 0;
`endif
            exp_q.push_back(v);
         end
   endtask

   task automatic pulse_start();
      step();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_fd(input int budget, input string name);
      bit ok;
      ok = 0;
      for (int k = 0; k < budget; k++) begin
         @(posedge clk);
         if (fd_seen) begin
            ok = 1;
            break;
         end
      end
      #1;
      if (!ok) chk({name, "_timeout"}, 0, 1);
   endtask

   task automatic wait_beats(input int n, input int budget, input string name);
      bit ok;
      ok = 0;
      for (int k = 0; k < budget; k++) begin
         @(posedge clk);
         if (beat_cnt >= n) begin
            ok = 1;
            break;
         end
      end
      #1;
      if (!ok) chk({name, "_timeout"}, 0, 1);
   endtask

   // cycles from first valid to frame_done for the ready pattern in force
   function automatic int drain_cycles(input int first, input int beats, input bit bp);
      int t;
      int n;
      t = first;
      n = 0;
      while (n < beats) begin
         if (!bp || pat[t % 4]) n++;
         t++;
      end
      return t - first;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int drv;
      int relu_exp;
      rst_n     = 1'b0;
      start     = 1'b0;
      done      = '0;
      in_values = '0;
      repeat (3) step();
      chk("rst_out_data", out_data, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_overrun", overrun, 0);
      rst_n = 1'b1;
      step();

      // basic frame: all done bits together
      fill_frame(0);
      build_exp();
      pulse_start();
      chk("busy_after_start", busy, 1);
      step();
      done = '1;
      drv  = cyc;
      wait_fd(400, "basic");
      chk("basic_beats", beat_cnt, NB);
      chk("basic_latency", first_valid_cyc - drv, 2);
      chk("basic_drain_cycles", fd_cyc - first_valid_cyc, drain_cycles(first_valid_cyc, NB, 0));
      chk("basic_drain_121", fd_cyc - first_valid_cyc, 121);
      chk("basic_beat1", beat_log[1], 1);
      chk("basic_beat11", beat_log[11], 16);
      chk("basic_beat120", beat_log[120], 170);
      chk("basic_overrun", overrun, 0);
      step();
      done = '0;

      // staggered done: column c rises 10+3c cycles after start
      build_exp();
      pulse_start();
      drv = 0;
      for (int t = 0; t < 46; t++) begin
         step();
         for (int c = 0; c < NC; c++) begin
            if (t == 10 + 3*c) begin
               done[c] = 1'b1;
               if (c == NC-1) drv = cyc;
            end
         end
      end
      wait_fd(400, "stagger");
      chk("stagger_beats", beat_cnt, NB);
      chk("stagger_latency", first_valid_cyc - drv, 2);
      chk("stagger_beat120", beat_log[120], 170);
      step();
      done = '0;

      // backpressure with a negative sample at [2][3]
      set_val(2, 3, -5);
      build_exp();
      rdy_mode = 1;
      pulse_start();
      step();
      done = '1;
      wait_fd(800, "bp");
      rdy_mode = 0;
`ifdef CONV_OUT_RELU_EN
      relu_exp = 0;
`else
      relu_exp = -5;
`endif
      chk("bp_beats", beat_cnt, NB);
      chk("bp_drain_cycles", fd_cyc - first_valid_cyc, drain_cycles(first_valid_cyc, NB, 1));
      chk("bp_beat24", beat_log[24], 34);
      chk("relu_beat25", beat_log[25], relu_exp);
      set_val(2, 3, 35);
      step();
      done = '0;

      // overrun: restart after beat 50 is accepted
      build_exp();
      pulse_start();
      step();
      done = '1;
      wait_beats(51, 400, "ovr_wait");
      start = 1'b1;
      done  = '0;
      exp_q.delete();
      step();
      start = 1'b0;
      chk("ovr_valid_drop", out_valid, 0);
      chk("ovr_flag", overrun, 1);
      chk("ovr_busy", busy, 1);
      fill_frame(256);
      build_exp();
      step();
      done = '1;
      wait_fd(400, "ovr_next");
      chk("ovr_next_beats", beat_cnt, NB);
      chk("ovr_next_beat0", beat_log[0], 256);
      chk("ovr_sticky", overrun, 1);
      step();
      done = '0;

      // reset in the middle of a drain
      build_exp();
      pulse_start();
      step();
      done = '1;
      wait_beats(60, 400, "rst_wait");
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_out_data", out_data, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_last", out_last, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_frame_done", frame_done, 0);
      chk("mid_rst_overrun", overrun, 0);
      step();
      done = '0;
      step();
      rst_n = 1'b1;
      repeat (2) step();
      done = '1;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("idle_ignore_busy", busy, 0);
         chk("idle_ignore_valid", out_valid, 0);
      end
      done = '0;
      repeat (2) step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/conv_out_serializer.md
# conv_out_serializer

Downstream stage of the column-convolution array. Captures the `COLS × OUT_W` feature map as each column engine raises its `done` bit. Once all columns are captured, streams the map out one sample per beat over a valid/ready handshake to the next layer. Decouples the parallel conv engines from the serial consumer and flags frame overruns.

## Interface

Parameters:
- `DATA_W`, 16, sample width (signed)
- `OUT_W`, 11, outputs per column
- `COLS`, 11, number of column engines

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  same pulse that starts the column engines; opens a new frame
- `done`  in  `COLS`  per-column completion from the column engines
- `in_values`  in  `COLS×OUT_W×DATA_W` signed  per-column results, valid when the matching `done` bit rises
- `out_data`  out  `DATA_W` signed  current sample
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer accepts the sample
- `out_last`  out  1  high with the final sample of the frame
- `busy`  out  1  high in CAPTURE or DRAIN
- `frame_done`  out  1  one-cycle pulse after the last beat is accepted
- `overrun`  out  1  sticky; `start` was seen while in DRAIN

## Operation

- **States:** IDLE, CAPTURE, DRAIN.
- **IDLE:**
  - `start` clears the capture flags and the beat index, then moves to CAPTURE.
  - `done` edges are ignored.
- **CAPTURE:**
  - A rising edge (`done[c] & ~done_q[c]`) copies `in_values[c]` into bank column c and sets `cap[c]`.
  - Several columns may rise in the same cycle; all of them are captured.
  - A repeat rising edge on an already-captured column overwrites that column.
  - When `cap` is all ones, move to DRAIN.
- **DRAIN:**
  - Beat index i runs 0..`COLS*OUT_W`-1; `out_data` = bank[i / `OUT_W`][i % `OUT_W`], column-major, row inner.
  - The index advances only on `out_valid & out_ready`.
  - `out_last` is high when i = `COLS*OUT_W`-1.
  - When the last beat is accepted, pulse `frame_done` and return to IDLE.
- **`start` during CAPTURE:** restart; clear `cap` and the index, stay in CAPTURE.
- **`start` during DRAIN:**
  - Set `overrun`.
  - Abort the drain with no `out_last` and no `frame_done`.
  - Clear `cap` and the index, enter CAPTURE.
  - `out_valid` drops the next cycle.
- **Clearing `overrun`:** only reset clears it.
- **Arithmetic:** no width change; samples pass through unmodified except for the optional ReLU (see Configuration).
- **`done_q`:** registered every cycle in all states, so a level-high `done` never re-triggers a capture.

## Timing

- **Reset values:** all outputs 0; state IDLE; `cap`, `done_q`, index and bank cleared to 0.
- **Capture latency:** a `done` rise at cycle t is stored at the t edge and `cap` is visible at t+1.
  - If that completes `cap`, state = DRAIN and `out_valid` = 1 at t+2.
- **Throughput:** one beat per cycle while `out_ready` is held high; a full frame drains in `COLS*OUT_W` (121) cycles.
- **Output stability:** `out_data`, `out_last` and `out_valid` are registered. They stay stable while `out_valid & ~out_ready`; no combinational path from `out_ready` to the outputs.
- **`frame_done`:** high in the cycle after the last handshake; `busy` is low that same cycle.
- **Reset mid-operation:** immediate return to reset values; any partial frame is discarded.

## Configuration

- **`CONV_OUT_RELU_EN` defined:** each captured sample goes through ReLU (negative → 0) at capture time, so the bank holds non-negative values.
- **`CONV_OUT_RELU_EN` undefined:** samples are stored and streamed signed, unchanged.
- Latency is identical in both builds.

## Structure

- **Shared package `conv_pkg`:**
  - `DATA_W`, `OUT_W`, `COLS` default constants.
  - `sample_t` (signed `DATA_W`).
  - State enum `ser_state_t` {IDLE, CAPTURE, DRAIN}.
  - `FRAME_LEN = COLS*OUT_W`.
- **Sub-module:** `col_capture_bank` holds the `COLS×OUT_W` register bank, with per-column write enable and optional ReLU. It exposes a single read port addressed by (col, row).
- **Top level:** FSM, edge detect, index counters and output register.

## Test plan

- **Basic frame:** reset, `start`, then all `done` bits rise together with `in_values[c][r]` = c*16+r, `out_ready` = 1.
  - Expect 121 beats in order 0,1,..,10,16,..; `out_last` on value 170; `frame_done` one cycle later.
- **Staggered done:** `done[c]` rises at cycle 10+3c.
  - Expect `out_valid` first high 2 cycles after `done[10]` rises; data identical to the basic frame.
- **Backpressure:** `out_ready` toggles 1,0,0,1 repeating.
  - Expect `out_data` held steady during stalls, no beat lost or duplicated, frame completes in 242 cycles.
- **Overrun:** `start` after beat 50 is accepted.
  - Expect `overrun` = 1 sticky, `out_valid` = 0 the next cycle, no `frame_done`; the next full capture drains from index 0.
- **ReLU build:** with `CONV_OUT_RELU_EN` defined, input −5 at [2][3] → output 0 at beat 25; without it → −5.
- **Reset mid-DRAIN:** assert `rst_n` low at beat 60.
  - Expect all outputs 0 and `overrun` = 0; a later IDLE ignores a `done` rise without `start`.
